// File: rtl/vid_mem_port_arbiter_pkg.sv
// Shared types and constants for the video memory port arbiter.
package vid_arb_pkg;

  localparam int BASE_W  = 3;
  localparam int REQ_WR  = 0;
  localparam int REQ_RD0 = 1;
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Index of the set bit of a one-hot 4-bit vector (0 when nothing is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/vid_mem_port_arbiter_if.sv
// Memory controller command/beat bus between the arbiter and the controller.
interface vid_mem_port_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 8
);
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_wr;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [LEN_W-1:0]  mem_cmd_len;
  logic              mem_beat;

  // Arbiter side: issues commands, observes acceptance and data beats.
  modport master (
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len,
    input  mem_cmd_ready, mem_beat
  );

  // Memory controller side.
  modport slave (
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len,
    output mem_cmd_ready, mem_beat
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker. Search starts at ptr and wraps;
// with FIXED_PRI0 set, bit 0 wins outright whenever it requests.
module rr_arbiter4 #(
  parameter bit FIXED_PRI0 = 1'b0
) (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  // First requester found walking upward from the pointer gets the grant.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt   = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    if (FIXED_PRI0 && req[0]) begin
      gnt = 4'b0001;
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vid_mem_port_arbiter.sv
// Shares one frame-buffer command port between one video writer and up to
// three video readers. The winner's frame base, offset and length are latched
// at grant time so a base swap never disturbs an in-flight burst.
// Build option: define WR_PRIORITY_EN to let the writer pre-empt the rotation.
module vid_mem_port_arbiter
  import vid_arb_pkg::*;
#(
  parameter int RDPORT   = 3,
  parameter int OFFSET_W = 24,
  parameter int LEN_W    = 8,
  parameter int ADDR_W   = OFFSET_W + BASE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [OFFSET_W-1:0]   wr_offset,
  input  logic [LEN_W-1:0]      wr_len,
  input  logic [BASE_W-1:0]     wr_base,
  input  logic [2:0]            rd_req,
  input  logic [3*OFFSET_W-1:0] rd_offset,
  input  logic [3*LEN_W-1:0]    rd_len,
  input  logic [BASE_W-1:0]     rd_base0,
  input  logic [BASE_W-1:0]     rd_base1,
  input  logic [BASE_W-1:0]     rd_base2,
  vid_mem_port_arbiter_if.master mem,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  wr_done,
  output logic [2:0]            rd_done,
  output logic                  busy
);

`ifdef WR_PRIORITY_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  arb_state_t            state_reg, state_next;
  logic [1:0]            ptr_reg;
  logic [NUM_REQ-1:0]    grant_reg;
  logic [NUM_REQ-1:0]    done_reg;
  logic                  wr_reg;
  logic [BASE_W-1:0]     base_reg;
  logic [OFFSET_W-1:0]   offset_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      beat_cnt_reg;

  logic [2:0]            rd_mask;
  logic [NUM_REQ-1:0]    req_vec;
  logic [NUM_REQ-1:0]    gnt_pick;
  logic [1:0]            win_idx;
  logic [BASE_W-1:0]     sel_base;
  logic [OFFSET_W-1:0]   sel_offset;
  logic [LEN_W-1:0]      sel_len;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  last_beat;

  // Read ports beyond RDPORT are permanently masked out of arbitration.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rd_mask
    assign rd_mask[gi] = (gi < RDPORT);
  end

  assign req_vec = {rd_req & rd_mask, wr_req};

  rr_arbiter4 #(.FIXED_PRI0(FIXED_PRI)) u_rr (
    .req (req_vec),
    .ptr (ptr_reg),
    .gnt (gnt_pick)
  );

  assign win_idx   = onehot_to_idx(gnt_pick);
  assign last_beat = mem.mem_beat && (beat_cnt_reg == len_reg);

  // Select the candidate winner's burst fields for latching.
  always_comb begin
    sel_base   = wr_base;
    sel_offset = wr_offset;
    sel_len    = wr_len;
    case (gnt_pick)
      4'b0010: begin
        sel_base   = rd_base0;
        sel_offset = rd_offset[0*OFFSET_W +: OFFSET_W];
        sel_len    = rd_len[0*LEN_W +: LEN_W];
      end
      4'b0100: begin
        sel_base   = rd_base1;
        sel_offset = rd_offset[1*OFFSET_W +: OFFSET_W];
        sel_len    = rd_len[1*LEN_W +: LEN_W];
      end
      4'b1000: begin
        sel_base   = rd_base2;
        sel_offset = rd_offset[2*OFFSET_W +: OFFSET_W];
        sel_len    = rd_len[2*LEN_W +: LEN_W];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: arbitrate, issue command, count beats, one-cycle done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (|req_vec)           state_next = CMD;
      CMD:  if (mem.mem_cmd_ready)  state_next = DATA;
      DATA: if (last_beat)          state_next = DONE;
      DONE:                         state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    mem.mem_cmd_valid = (state_reg == CMD);
    busy              = (state_reg != IDLE);
  end

  // Grant, latched burst fields, rotation pointer, beat counter and done strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= 2'd0;
      grant_reg    <= '0;
      done_reg     <= '0;
      wr_reg       <= 1'b0;
      base_reg     <= '0;
      offset_reg   <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            grant_reg  <= gnt_pick;
            wr_reg     <= gnt_pick[REQ_WR];
            base_reg   <= sel_base;
            offset_reg <= sel_offset;
            len_reg    <= sel_len;
            ptr_reg    <= win_idx + 2'd1;
          end
        end
        CMD: begin
          if (mem.mem_cmd_ready) beat_cnt_reg <= '0;
        end
        DATA: begin
          if (last_beat)         done_reg     <= grant_reg;
          else if (mem.mem_beat) beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
        DONE: begin
          grant_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_addr         = {base_reg, offset_reg};
  assign mem.mem_cmd_addr = cmd_addr;
  assign mem.mem_cmd_len  = len_reg;
  assign mem.mem_cmd_wr   = wr_reg;
  assign grant            = grant_reg;
  assign wr_done          = done_reg[REQ_WR];
  assign rd_done          = done_reg[REQ_RD0 +: 3];

endmodule
